// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// arbitrates the single memory port, flags illegal/system opcodes and counts retirements.
module multicycle_controller #(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [6:0]  i_opcode,
    input  logic        i_branch_taken,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_addr_sel,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_src,
    output logic        o_rf_we,
    output logic        o_frf_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_alu_a_sel,
    output logic        o_alu_b_sel,
    output logic        o_store_fp,
    output logic        o_halt,
    output logic        o_illegal,
    output logic [2:0]  o_state,
    output logic [31:0] o_instret
);

    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               retire;
    logic               illegal_set;
    logic               illegal_q;
    logic [CNT_W-1:0]   instret_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_BOOT;
        else          state <= state_nxt;
    end

    // Sticky illegal-opcode flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         illegal_q <= 1'b0;
        else if (illegal_set) illegal_q <= 1'b1;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    instret_q <= '0;
        else if (retire) instret_q <= instret_q + CNT_W'(1);
    end

    assign o_state   = 3'(state);
    assign o_illegal = illegal_q;
    assign o_instret = instret_q;

    // Next-state and control decode
    always_comb begin
        state_nxt      = state;
        retire         = 1'b0;
        illegal_set    = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_ir_we        = 1'b0;
        o_pc_we        = 1'b0;
        o_pc_src       = 2'd0;
        o_rf_we        = 1'b0;
        o_frf_we       = 1'b0;
        o_wb_sel       = 2'd0;
        o_alu_a_sel    = 1'b0;
        o_alu_b_sel    = 1'b0;
        o_store_fp     = 1'b0;
        o_halt         = 1'b0;

        case (state)
            S_BOOT: begin
                if (!RESET_HALT || i_start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_we   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (i_opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH, OPC_JAL,
                    OPC_JALR, OPC_LOAD, OPC_STORE, OPC_FLW, OPC_FSW, OPC_FENCE:
                        state_nxt = S_EXEC;
                    OPC_SYSTEM:
                        state_nxt = S_HALT;
                    default: begin
                        state_nxt   = S_HALT;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                o_pc_we   = 1'b1;
                retire    = 1'b1;
                case (i_opcode)
                    OPC_OP: o_rf_we = 1'b1;
                    OPC_OP_IMM, OPC_LUI: begin
                        o_rf_we     = 1'b1;
                        o_alu_b_sel = 1'b1;
                    end
                    OPC_AUIPC: begin
                        o_rf_we     = 1'b1;
                        o_alu_a_sel = 1'b1;
                        o_alu_b_sel = 1'b1;
                    end
                    OPC_FENCE: ;
                    OPC_BRANCH: o_pc_src = i_branch_taken ? 2'd2 : 2'd0;
                    OPC_JAL: begin
                        o_rf_we  = 1'b1;
                        o_wb_sel = 2'd2;
                        o_pc_src = 2'd2;
                    end
                    OPC_JALR: begin
                        o_rf_we     = 1'b1;
                        o_wb_sel    = 2'd2;
                        o_pc_src    = 2'd1;
                        o_alu_b_sel = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE, OPC_FLW, OPC_FSW: begin
                        o_pc_we     = 1'b0;
                        retire      = 1'b0;
                        o_alu_b_sel = 1'b1;
                        state_nxt   = S_MEM;
                    end
                    default: begin
                        // opcode changed under us after decode: treat as illegal
                        o_pc_we     = 1'b0;
                        retire      = 1'b0;
                        illegal_set = 1'b1;
                        state_nxt   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_alu_b_sel    = 1'b1;
                o_mem_we       = (i_opcode == OPC_STORE) || (i_opcode == OPC_FSW);
                o_store_fp     = (i_opcode == OPC_FSW);
                if (i_mem_ready) begin
                    if (o_mem_we) begin
                        o_pc_we   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                o_wb_sel  = 2'd1;
                o_pc_we   = 1'b1;
                retire    = 1'b1;
                o_rf_we   = (i_opcode == OPC_LOAD);
                o_frf_we  = (i_opcode == OPC_FLW);
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                o_halt = 1'b1;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] OPR   = 7'b0110011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] FLW   = 7'b0000111;
    localparam logic [6:0] FSW   = 7'b0100111;
    localparam logic [6:0] FENCE = 7'b0001111;
    localparam logic [6:0] ECALL = 7'b1110011;
    localparam logic [6:0] BAD   = 7'b1111111;

    localparam int F_REQ = 1 << 0;
    localparam int F_WE  = 1 << 1;
    localparam int F_ADR = 1 << 2;
    localparam int F_IR  = 1 << 3;
    localparam int F_PC  = 1 << 4;
    localparam int F_RF  = 1 << 5;
    localparam int F_FRF = 1 << 6;
    localparam int F_A   = 1 << 7;
    localparam int F_B   = 1 << 8;
    localparam int F_SFP = 1 << 9;
    localparam int F_HLT = 1 << 10;
    localparam int F_ILL = 1 << 11;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwe, adr, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       rfwe, frfwe;
        logic [1:0] wbsel;
        logic       asel, bsel, sfp, halt, ill;
    } ctl_t;

    typedef struct {
        string       name;
        ctl_t        ctl;
        logic [31:0] instret;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, frf_we;
    logic        alu_a_sel, alu_b_sel, store_fp, halt, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    ctl_t act;

    multicycle_controller #(.RESET_HALT(1'b0)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_opcode       (opcode),
        .i_branch_taken (branch_taken),
        .i_mem_ready    (mem_ready),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr_sel (mem_addr_sel),
        .o_ir_we        (ir_we),
        .o_pc_we        (pc_we),
        .o_pc_src       (pc_src),
        .o_rf_we        (rf_we),
        .o_frf_we       (frf_we),
        .o_wb_sel       (wb_sel),
        .o_alu_a_sel    (alu_a_sel),
        .o_alu_b_sel    (alu_b_sel),
        .o_store_fp     (store_fp),
        .o_halt         (halt),
        .o_illegal      (illegal),
        .o_state        (state),
        .o_instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        act       = '0;
        act.st    = state;
        act.mreq  = mem_req;
        act.mwe   = mem_we;
        act.adr   = mem_addr_sel;
        act.irwe  = ir_we;
        act.pcwe  = pc_we;
        act.pcsrc = pc_src;
        act.rfwe  = rf_we;
        act.frfwe = frf_we;
        act.wbsel = wb_sel;
        act.asel  = alu_a_sel;
        act.bsel  = alu_b_sel;
        act.sfp   = store_fp;
        act.halt  = halt;
        act.ill   = illegal;
    end

    function automatic ctl_t e(int st, int f, int pcs = 0, int wb = 0);
        ctl_t c;
        c.st    = 3'(st);
        c.mreq  = (f & F_REQ) != 0;
        c.mwe   = (f & F_WE)  != 0;
        c.adr   = (f & F_ADR) != 0;
        c.irwe  = (f & F_IR)  != 0;
        c.pcwe  = (f & F_PC)  != 0;
        c.pcsrc = 2'(pcs);
        c.rfwe  = (f & F_RF)  != 0;
        c.frfwe = (f & F_FRF) != 0;
        c.wbsel = 2'(wb);
        c.asel  = (f & F_A)   != 0;
        c.bsel  = (f & F_B)   != 0;
        c.sfp   = (f & F_SFP) != 0;
        c.halt  = (f & F_HLT) != 0;
        c.ill   = (f & F_ILL) != 0;
        return c;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic cyc(input logic rst, input logic [6:0] opc, input logic rdy, input logic tk,
                       input ctl_t ex, input logic [31:0] ir, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n        = rst;
        opcode       = opc;
        mem_ready    = rdy;
        branch_taken = tk;
        x.name       = name;
        x.ctl        = ex;
        x.instret    = ir;
        q.push_back(x);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (act !== x.ctl) begin
                errors++;
                $display("FAIL %s ctl actual=%05h required=%05h", x.name, act, x.ctl);
            end
            checks++;
            if (instret !== x.instret) begin
                errors++;
                $display("FAIL %s instret actual=%08h required=%08h", x.name, instret, x.instret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;

        cyc(0, 0,    0, 0, e(0, 0), 0, "reset");
        cyc(0, 0,    1, 0, e(0, 0), 0, "reset_rdy");
        cyc(1, 0,    1, 0, e(0, 0), 0, "boot");
        // addi, zero-wait
        cyc(1, ADDI, 1, 0, e(1, F_REQ|F_IR), 0, "addi_fetch");
        cyc(1, ADDI, 1, 0, e(2, 0), 0, "addi_decode");
        cyc(1, ADDI, 0, 0, e(3, F_PC|F_RF|F_B), 0, "addi_exec");
        // lw, 2 waits in fetch and 2 in mem
        cyc(1, LW,   0, 0, e(1, F_REQ), 1, "lw_fwait1");
        cyc(1, LW,   0, 0, e(1, F_REQ), 1, "lw_fwait2");
        cyc(1, LW,   1, 0, e(1, F_REQ|F_IR), 1, "lw_fetch");
        cyc(1, LW,   1, 0, e(2, 0), 1, "lw_decode");
        cyc(1, LW,   1, 0, e(3, F_B), 1, "lw_exec");
        cyc(1, LW,   0, 0, e(4, F_REQ|F_ADR|F_B), 1, "lw_mwait1");
        cyc(1, LW,   0, 0, e(4, F_REQ|F_ADR|F_B), 1, "lw_mwait2");
        cyc(1, LW,   1, 0, e(4, F_REQ|F_ADR|F_B), 1, "lw_mem");
        cyc(1, LW,   0, 0, e(5, F_PC|F_RF, 0, 1), 1, "lw_wb");
        // beq taken, then not taken
        cyc(1, BEQ,  1, 0, e(1, F_REQ|F_IR), 2, "beq1_fetch");
        cyc(1, BEQ,  0, 0, e(2, 0), 2, "beq1_decode");
        cyc(1, BEQ,  0, 1, e(3, F_PC, 2), 2, "beq1_exec");
        cyc(1, BEQ,  1, 0, e(1, F_REQ|F_IR), 3, "beq0_fetch");
        cyc(1, BEQ,  0, 1, e(2, 0), 3, "beq0_decode");
        cyc(1, BEQ,  0, 0, e(3, F_PC, 0), 3, "beq0_exec");
        // fsw then flw
        cyc(1, FSW,  1, 0, e(1, F_REQ|F_IR), 4, "fsw_fetch");
        cyc(1, FSW,  0, 0, e(2, 0), 4, "fsw_decode");
        cyc(1, FSW,  0, 0, e(3, F_B), 4, "fsw_exec");
        cyc(1, FSW,  1, 0, e(4, F_REQ|F_WE|F_ADR|F_B|F_SFP|F_PC), 4, "fsw_mem");
        cyc(1, FLW,  1, 0, e(1, F_REQ|F_IR), 5, "flw_fetch");
        cyc(1, FLW,  0, 0, e(2, 0), 5, "flw_decode");
        cyc(1, FLW,  0, 0, e(3, F_B), 5, "flw_exec");
        cyc(1, FLW,  1, 0, e(4, F_REQ|F_ADR|F_B), 5, "flw_mem");
        cyc(1, FLW,  0, 0, e(5, F_PC|F_FRF, 0, 1), 5, "flw_wb");
        // unsupported opcode halts sticky-illegal
        cyc(1, BAD,  1, 0, e(1, F_REQ|F_IR), 6, "bad_fetch");
        cyc(1, BAD,  1, 0, e(2, 0), 6, "bad_decode");
        cyc(1, BAD,  0, 0, e(6, F_HLT|F_ILL), 6, "bad_halt1");
        cyc(1, BAD,  1, 0, e(6, F_HLT|F_ILL), 6, "bad_halt2");
        cyc(1, ADDI, 1, 0, e(6, F_HLT|F_ILL), 6, "bad_halt3");
        // ecall halts without illegal
        cyc(0, ECALL, 1, 0, e(0, 0), 0, "rst2");
        cyc(1, ECALL, 1, 0, e(0, 0), 0, "boot2");
        cyc(1, ECALL, 1, 0, e(1, F_REQ|F_IR), 0, "ecall_fetch");
        cyc(1, ECALL, 0, 0, e(2, 0), 0, "ecall_decode");
        cyc(1, ECALL, 1, 0, e(6, F_HLT), 0, "ecall_halt1");
        cyc(1, ADDI,  1, 0, e(6, F_HLT), 0, "ecall_halt2");
        // counter wrap, then remaining opcode classes
        cyc(0, JAL,  0, 0, e(0, 0), 0, "rst3");
        cyc(1, JAL,  0, 0, e(0, 0), 32'hFFFF_FFFF, "boot3_preload");
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cyc(1, JAL,  1, 0, e(1, F_REQ|F_IR), 32'hFFFF_FFFF, "jal_fetch");
        cyc(1, JAL,  0, 0, e(2, 0), 32'hFFFF_FFFF, "jal_decode");
        cyc(1, JAL,  0, 0, e(3, F_PC|F_RF, 2, 2), 32'hFFFF_FFFF, "jal_exec");
        cyc(1, JALR, 1, 0, e(1, F_REQ|F_IR), 0, "wrap_jalr_fetch");
        cyc(1, JALR, 0, 0, e(2, 0), 0, "jalr_decode");
        cyc(1, JALR, 0, 0, e(3, F_PC|F_RF|F_B, 1, 2), 0, "jalr_exec");
        cyc(1, LUI,  1, 0, e(1, F_REQ|F_IR), 1, "lui_fetch");
        cyc(1, LUI,  0, 0, e(2, 0), 1, "lui_decode");
        cyc(1, LUI,  0, 0, e(3, F_PC|F_RF|F_B), 1, "lui_exec");
        cyc(1, AUIPC, 1, 0, e(1, F_REQ|F_IR), 2, "auipc_fetch");
        cyc(1, AUIPC, 0, 0, e(2, 0), 2, "auipc_decode");
        cyc(1, AUIPC, 0, 0, e(3, F_PC|F_RF|F_A|F_B), 2, "auipc_exec");
        cyc(1, OPR,  1, 0, e(1, F_REQ|F_IR), 3, "op_fetch");
        cyc(1, OPR,  0, 0, e(2, 0), 3, "op_decode");
        cyc(1, OPR,  0, 0, e(3, F_PC|F_RF), 3, "op_exec");
        cyc(1, FENCE, 1, 0, e(1, F_REQ|F_IR), 4, "fence_fetch");
        cyc(1, FENCE, 0, 0, e(2, 0), 4, "fence_decode");
        cyc(1, FENCE, 0, 0, e(3, F_PC), 4, "fence_exec");
        // sw interrupted by reset during a memory wait
        cyc(1, SW,   1, 0, e(1, F_REQ|F_IR), 5, "sw_fetch");
        cyc(1, SW,   0, 0, e(2, 0), 5, "sw_decode");
        cyc(1, SW,   0, 0, e(3, F_B), 5, "sw_exec");
        cyc(1, SW,   0, 0, e(4, F_REQ|F_WE|F_ADR|F_B), 5, "sw_mwait");
        cyc(0, SW,   1, 0, e(0, 0), 0, "rst_in_mem");
        cyc(0, SW,   1, 0, e(0, 0), 0, "rst_in_mem_rdy");
        cyc(1, SW,   1, 0, e(0, 0), 0, "boot4");
        cyc(1, SW,   0, 0, e(1, F_REQ), 0, "fetch4");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
